// File: rtl/butterfly_sequencer_unit.sv
// Sequencer for an in-place radix-2 FFT: steps the butterfly address generator
// through AWL layers, drains the butterfly pipeline between layers, and aligns write-back.
module butterfly_sequencer_unit #(
    parameter int AWL    = 5,
    parameter int BF_LAT = 2,
    localparam int LW    = ($clog2(AWL) > 1) ? $clog2(AWL) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [AWL-1:0] a_addr,
    input  logic [AWL-1:0] b_addr,
    output logic           en,
    output logic           lay_en,
    output logic [LW-1:0]  layer,
    output logic [AWL-2:0] w_addr,
    output logic           wr_en,
    output logic [AWL-1:0] wr_a_addr,
    output logic [AWL-1:0] wr_b_addr,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    localparam int             DW         = $clog2(BF_LAT + 1);
    localparam int             EW         = 1 + 2 * AWL;
    localparam logic [AWL-2:0] BF_LAST    = '1;
    localparam logic [DW-1:0]  DRAIN_LAST = DW'(BF_LAT - 1);
    localparam logic [LW-1:0]  LAYER_LAST = LW'(AWL - 1);

    state_t         state;
    state_t         state_nxt;
    logic [AWL-2:0] bf_cnt;
    logic [DW-1:0]  drain_cnt;
    logic [AWL-2:0] w_mask;
    logic [EW-1:0]  pipe [BF_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bf_cnt    <= '0;
            drain_cnt <= '0;
            layer     <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
            // The butterfly counter wraps at N/2 on its own, in step with the generator.
            if (en) begin
                bf_cnt <= bf_cnt + 1'b1;
            end
            if (lay_en) begin
                layer <= (layer == LAYER_LAST) ? '0 : layer + 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt = state;
        en        = 1'b0;
        lay_en    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                en = 1'b1;
                if (bf_cnt == BF_LAST) begin
                    lay_en    = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // The layer index has already advanced, so wrapping to 0 marks the final layer.
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = (layer == '0) ? FIN : RUN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Twiddle index: low LAYER bits of A, left-justified into the AWL-1 bit ROM address.
    always_comb begin
        w_mask = ~({(AWL-1){1'b1}} << layer);
        w_addr = (a_addr[AWL-2:0] & w_mask) << (LAYER_LAST - layer);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the delay line is reset explicitly so an abort cannot leak a stale write strobe.
            for (int i = 0; i < BF_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= {en, a_addr, b_addr};
            for (int i = 1; i < BF_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign {wr_en, wr_a_addr, wr_b_addr} = pipe[BF_LAT-1];

endmodule
